// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths and select encodings for the writeback stage
package pipe_pkg;

  localparam int DW       = 32;
  localparam int AW       = 5;
  localparam int NREGS    = 32;
  localparam int ZERO_REG = 0;

  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;

endpackage

// File: rtl/wb_mux.sv
// rtl/wb_mux.sv - 2:1 writeback value select (load data vs ALU result)
module wb_mux
  import pipe_pkg::*;
#(
  parameter int W = pipe_pkg::DW
) (
  input  logic         sel,
  input  logic [W-1:0] mem_data,
  input  logic [W-1:0] alu_result,
  output logic [W-1:0] y
);

  always_comb begin
    y = (sel == WB_SEL_MEM) ? mem_data : alu_result;
  end

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback stage, 2-read/1-write register file, retire counter
// Optional WB_BYPASS_EN: read ports forward the in-flight writeback value.
module wb_regfile
  import pipe_pkg::*;
#(
  parameter int NREGS = pipe_pkg::NREGS,
  parameter int AW    = pipe_pkg::AW,
  parameter int DW    = pipe_pkg::DW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [DW-1:0] wb_mem_data,
  input  logic [AW-1:0] wb_dest,
  input  logic          wb_regwrite,
  input  logic [DW-1:0] wb_alu_result,
  input  logic          wb_memtoreg,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  output logic [DW-1:0] rs_data,
  output logic [DW-1:0] rt_data,
  output logic [DW-1:0] wb_data,
  output logic [31:0]   retire_count
);

  logic [DW-1:0] regs_q [NREGS];
  logic [DW-1:0] regs_d [NREGS];
  logic [31:0]   retire_count_q;
  logic [31:0]   retire_count_d;
  logic          commit;

  wb_mux #(.W(DW)) u_wb_mux (
    .sel        (wb_memtoreg),
    .mem_data   (wb_mem_data),
    .alu_result (wb_alu_result),
    .y          (wb_data)
  );

  // Writes to r0 are dropped entirely, including from the retire count.
  assign commit = wb_regwrite && (wb_dest != AW'(ZERO_REG));

  always_comb begin
    regs_d         = regs_q;
    retire_count_d = retire_count_q;
    if (commit) begin
      regs_d[wb_dest] = wb_data;
      retire_count_d  = retire_count_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      retire_count_q <= '0;
    end else begin
      regs_q         <= regs_d;
      retire_count_q <= retire_count_d;
    end
  end

  always_comb begin
    rs_data = (rs_addr == AW'(ZERO_REG)) ? '0 : regs_q[rs_addr];
    rt_data = (rt_addr == AW'(ZERO_REG)) ? '0 : regs_q[rt_addr];
`ifdef WB_BYPASS_EN
    if (commit && (wb_dest == rs_addr)) begin
      rs_data = wb_data;
    end
    if (commit && (wb_dest == rt_addr)) begin
      rt_data = wb_data;
    end
`endif
  end

  assign retire_count = retire_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - scoreboard bench for wb_regfile against a register-array model
module tb_wb_regfile;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] wb_mem_data;
  logic [4:0]  wb_dest;
  logic        wb_regwrite;
  logic [31:0] wb_alu_result;
  logic        wb_memtoreg;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] wb_data;
  logic [31:0] retire_count;

  wb_regfile dut (
    .clock         (clock),
    .reset         (reset),
    .wb_mem_data   (wb_mem_data),
    .wb_dest       (wb_dest),
    .wb_regwrite   (wb_regwrite),
    .wb_alu_result (wb_alu_result),
    .wb_memtoreg   (wb_memtoreg),
    .rs_addr       (rs_addr),
    .rt_addr       (rt_addr),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .wb_data       (wb_data),
    .retire_count  (retire_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          tag;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] wb;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [32];
  logic [31:0] model_cnt;
  bit          inited = 0;
  int          checks = 0;
  int          errors = 0;
  int          tag    = 0;

  function automatic logic [31:0] model_read(input logic [4:0] a, input bit we,
                                             input logic [4:0] dest, input logic [31:0] wbv);
    if (a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (we && dest == a) return wbv;
`endif
    return model[a];
  endfunction

  task automatic step(input bit rst, input bit we, input bit m2r, input logic [4:0] dest,
                      input logic [31:0] alu, input logic [31:0] mem,
                      input logic [4:0] rs, input logic [4:0] rt);
    exp_t        e;
    logic [31:0] wbv;
    reset = rst; wb_regwrite = we; wb_memtoreg = m2r; wb_dest = dest;
    wb_alu_result = alu; wb_mem_data = mem; rs_addr = rs; rt_addr = rt;
    wbv = m2r ? mem : alu;
    if (inited) begin
      e.tag = tag;
      e.rs  = model_read(rs, we, dest, wbv);
      e.rt  = model_read(rt, we, dest, wbv);
      e.wb  = wbv;
      e.cnt = model_cnt;
      sb.push_back(e);
    end
    tag++;
    @(posedge clock);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      model_cnt = 32'd0;
      inited = 1;
    end else if (we && dest != 5'd0) begin
      model[dest] = wbv;
      model_cnt   = model_cnt + 32'd1;
    end
    #1;
  endtask

  task automatic chk(input string name, input int t, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s tag=%0d got=%h exp=%h", name, t, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("rs_data", e.tag, rs_data, e.rs);
      chk("rt_data", e.tag, rt_data, e.rt);
      chk("wb_data", e.tag, wb_data, e.wb);
      chk("retire_count", e.tag, retire_count, e.cnt);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 5, 31);
    // ALU writeback then load writeback, then a dropped r0 write
    step(0, 1, 0, 8, 32'h0000_1234, 32'hAAAA_AAAA, 5, 31);
    step(0, 1, 1, 9, 32'h1111_1111, 32'hDEAD_BEEF, 8, 0);
    step(0, 1, 0, 0, 32'hFFFF_FFFF, 32'h0, 9, 0);
    step(0, 0, 0, 0, 0, 0, 0, 9);
    // same-cycle hazard on r10, both ports on the same register
    step(0, 1, 0, 10, 32'h11, 0, 8, 9);
    step(0, 1, 0, 10, 32'h22, 0, 10, 10);
    step(0, 0, 0, 0, 0, 0, 10, 10);
    // reset wins over a same-edge write
    step(1, 1, 0, 12, 32'h55, 0, 12, 10);
    step(0, 0, 0, 0, 0, 0, 12, 10);
    // counter wrap
    dut.retire_count_q = 32'hFFFF_FFFF;
    model_cnt = 32'hFFFF_FFFF;
    step(0, 1, 1, 3, 0, 32'h0BAD_F00D, 3, 0);
    step(0, 0, 0, 0, 0, 0, 3, 3);
    for (int i = 0; i < 400; i++) begin
      logic [4:0] d;
      d = 5'($urandom_range(0, 31));
      step(($urandom % 50) == 0, ($urandom % 3) != 0, 1'($urandom),
           d, $urandom, $urandom,
           (($urandom % 3) == 0) ? d : 5'($urandom),
           (($urandom % 3) == 0) ? d : 5'($urandom));
    end
    repeat (3) @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline interface: writeback stage plus the 32x32 architectural register file of the 5-stage pipeline.
- Takes the MEM/WB register outputs: memory read data, destination register, regwrite, ALU result and memtoreg.
- Selects the writeback value and commits it on the clock edge.
- Serves two combinational read ports to the ID stage.
- Keeps a retired-write counter for performance and debug.

Parameters:
- NREGS, 32, number of architectural registers; must be 2**AW.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clock  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- wb_mem_data  input  DW  load data from the MEM/WB register.
- wb_dest  input  AW  destination register index from the MEM/WB register.
- wb_regwrite  input  1  write enable from the MEM/WB register.
- wb_alu_result  input  DW  ALU result from the MEM/WB register.
- wb_memtoreg  input  1  1 = write wb_mem_data, 0 = write wb_alu_result.
- rs_addr  input  AW  read port A address (ID stage).
- rt_addr  input  AW  read port B address (ID stage).
- rs_data  output  DW  read port A data, combinational.
- rt_data  output  DW  read port B data, combinational.
- wb_data  output  DW  selected writeback value, combinational; also feeds the EX forwarding unit.
- retire_count  output  32  count of committed register writes.

Behaviour:
- Reset: synchronous, active-high. On a rising edge with reset=1:
  - all NREGS registers clear to 0;
  - retire_count clears to 0;
  - no write commits, even if wb_regwrite=1 in the same cycle (reset has priority).
- Writeback mux: wb_data = wb_memtoreg ? wb_mem_data : wb_alu_result. Pure combinational.
- Write commit, evaluated at the rising edge when reset=0:
  - if wb_regwrite=1 and wb_dest!=0, regs[wb_dest] <= wb_data;
  - retire_count <= retire_count+1.
  - Latency: the value is visible in storage one edge after being presented.
- Register 0: always reads 0. Writes to index 0 are dropped and are not counted.
- wb_regwrite=0: storage and counter both hold. wb_memtoreg, wb_dest and data inputs are don't-care.
- Read ports:
  - Asynchronous reads of storage; rs_addr==0 or rt_addr==0 returns 0.
  - Both ports may address the same register at once; both return the same value.
- Same-cycle read/write of one register: the result is governed by WB_BYPASS_EN (see Optional Feature).
- retire_count: 32-bit unsigned, wraps 0xFFFFFFFF -> 0x00000000 without a flag.
- Reset mid-stream: a writeback in flight during the reset cycle is lost. The pipeline re-fetches after reset.
- No X propagation: storage is fully initialised by the first reset. Before the first reset, contents are undefined and the bench must not check them.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: a read port returns wb_data in the same cycle when all of the following hold:
  - wb_regwrite=1;
  - wb_dest==its address;
  - its address !=0.
  - This removes the WB->ID RAW hazard with no stall.
- Undefined: read ports return stored contents only. A same-cycle read gets the old value; the hazard unit must stall ID one cycle on a WB->ID match.
- retire_count and wb_data are unaffected either way.

Decomposition:
- Shared package pipe_pkg:
  - DW, AW, NREGS;
  - ZERO_REG index constant (0);
  - memtoreg select encodings WB_SEL_ALU=0 and WB_SEL_MEM=1.
- One natural sub-module, wb_mux: the 2:1 writeback select, reusable by the forwarding unit.
- Storage, read ports and counter stay in wb_regfile.

Test Plan:
- Reset then read: assert reset one cycle. Read rs_addr=5, rt_addr=31 -> both 0, retire_count=0.
- ALU writeback: wb_regwrite=1, wb_memtoreg=0, wb_dest=8, wb_alu_result=0x0000_1234 for one edge. Next cycle rs_addr=8 -> 0x0000_1234, retire_count=1.
- Load writeback and r0:
  - Write wb_dest=9, wb_memtoreg=1, wb_mem_data=0xDEAD_BEEF -> r9 reads 0xDEAD_BEEF.
  - Write wb_dest=0, value 0xFFFF_FFFF -> r0 reads 0, retire_count increments only for r9.
- Same-cycle hazard: r10=0x11 stored. Present a write of r10=0x22 with rs_addr=10 in the same cycle:
  - with WB_BYPASS_EN, rs_data=0x22 before the edge;
  - without it, rs_data=0x11 before the edge and 0x22 after.
- Reset priority: reset=1 and a write of r12=0x55 on the same edge -> r12 reads 0, retire_count=0.
- Counter wrap: force retire_count to 0xFFFF_FFFF (hierarchical deposit), do one valid write -> retire_count=0.
